// File: rtl/nxs_serial_pkg.sv
// Shared definitions for the serial message receive path: defaults, state
// encoding and byte-lane helper.
package nxs_serial_pkg;

  localparam int         MSG_LEN_DEF   = 216;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // LSB position of byte k inside a packed message word, for [byte_lsb(k) +: 8].
  function automatic int byte_lsb(input int k);
    return 8 * k;
  endfunction

endpackage

// File: rtl/serial_msg_rx_if.sv
// Byte-strobe input and message valid/ready output bundle of serial_msg_rx.
interface serial_msg_rx_if
  import nxs_serial_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
);

  localparam int CNT_W = $clog2(MSG_LEN + 1);

  logic                   rx_valid;
  logic [7:0]             rx_byte;
  logic                   msg_ready;
  logic                   msg_valid;
  logic [MSG_LEN*8-1:0]   msg_data;
  logic [CNT_W-1:0]       byte_cnt;
  logic                   timeout_err;
  logic                   overrun_err;

  modport slave (
    input  rx_valid, rx_byte, msg_ready,
    output msg_valid, msg_data, byte_cnt, timeout_err, overrun_err
  );

  modport master (
    output rx_valid, rx_byte, msg_ready,
    input  msg_valid, msg_data, byte_cnt, timeout_err, overrun_err
  );

endinterface

// File: rtl/serial_idle_timer.sv
// Saturating idle counter: counts while run is high, restarts on clear or when
// stopped, and flags expire once TIMEOUT_CYC cycles have elapsed.
module serial_idle_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst_n, clear, run};
    assign expire    = 1'b0;
  end else begin : g_on
    localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count <= '0;
      end else if (clear || !run) begin
        count <= '0;
      end else if (count != LIMIT) begin
        count <= count + TW'(1);
      end
    end

    assign expire = run && (count == LIMIT);
  end

endmodule

// File: rtl/serial_msg_rx.sv
// Assembles MSG_LEN received bytes into one word and offers it on a
// valid/ready handshake with optional sync framing and inter-byte timeout.
//
//   state      | meaning
//   ST_HUNT    | waiting for SYNC_BYTE (only reachable when SYNC_EN=1)
//   ST_COLLECT | accepting payload bytes into the assembly register
module serial_msg_rx
  import nxs_serial_pkg::*;
#(
  parameter int         MSG_LEN     = MSG_LEN_DEF,
  parameter int         SYNC_EN     = 0,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_msg_rx_if.slave  bus
);

  localparam int               W        = MSG_LEN * 8;
  localparam int               CNT_W    = $clog2(MSG_LEN + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(MSG_LEN - 1);
  localparam logic [0:0]       ST_START = (SYNC_EN != 0) ? ST_HUNT : ST_COLLECT;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     asm_q;
  logic [W-1:0]     asm_d;
  logic [W-1:0]     data_q;
  logic             valid_q;
  logic             timeout_q;
  logic             overrun_q;

  logic accept;
  logic complete;
  logic load;
  logic run;
  logic expire;
  logic timeout;

  // New byte enters at the top so the first byte ends up in lane 0.
  assign asm_d    = W'({bus.rx_byte, asm_q} >> 8);

  assign accept   = bus.rx_valid && (state == ST_COLLECT);
  assign complete = accept && (cnt == LAST);
  assign load     = complete && (!valid_q || bus.msg_ready);
  assign run      = (cnt != '0) || ((SYNC_EN != 0) && (state == ST_COLLECT));
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout  = expire && !accept;

  serial_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept || timeout),
    .run    (run),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_START;
      cnt       <= '0;
      asm_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timeout_q <= timeout;
      overrun_q <= complete && !load;

      if (accept) begin
        asm_q <= asm_d;
      end

      if (state == ST_HUNT) begin
        if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) begin
          state <= ST_COLLECT;
        end
      end else if (complete) begin
        cnt   <= '0;
        state <= ST_START;
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
      end else if (timeout) begin
        cnt   <= '0;
        state <= ST_START;
      end

      if (load) begin
        data_q  <= asm_d;
        valid_q <= 1'b1;
      end else if (valid_q && bus.msg_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.msg_valid   = valid_q;
  assign bus.msg_data    = data_q;
  assign bus.byte_cnt    = cnt;
  assign bus.timeout_err = timeout_q;
  assign bus.overrun_err = overrun_q;

endmodule

// File: tb/tb_serial_msg_rx.sv
// Scoreboard bench for serial_msg_rx: one unframed instance with a 50-cycle
// timeout and one sync-framed instance without timeout, both MSG_LEN=4.
module tb_serial_msg_rx;
  import nxs_serial_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_msg_rx_if #(.MSG_LEN(4)) ia ();
  serial_msg_rx_if #(.MSG_LEN(4)) ib ();

  serial_msg_rx #(
    .MSG_LEN(4), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(50)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );

  serial_msg_rx #(
    .MSG_LEN(4), .SYNC_EN(1), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  int checks = 0;
  int errors = 0;
  int ov_a = 0;
  int to_a = 0;
  int ov_b = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: every accepted message is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ia.msg_valid && ia.msg_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL mon_a: got unexpected message %h, expected none", ia.msg_data);
      end else begin
        exp_a = qa.pop_front();
        if (ia.msg_data !== exp_a) begin
          errors++;
          $display("FAIL mon_a: got %h, expected %h", ia.msg_data, exp_a);
        end
      end
    end
    if (rst_n && ia.overrun_err) ov_a++;
    if (rst_n && ia.timeout_err) to_a++;
  end

  always @(negedge clk) begin
    if (rst_n && ib.msg_valid && ib.msg_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL mon_b: got unexpected message %h, expected none", ib.msg_data);
      end else begin
        exp_b = qb.pop_front();
        if (ib.msg_data !== exp_b) begin
          errors++;
          $display("FAIL mon_b: got %h, expected %h", ib.msg_data, exp_b);
        end
      end
    end
    if (rst_n && ib.overrun_err) ov_b++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    ia.rx_byte  = b;
    ia.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    ia.rx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    ib.rx_byte  = b;
    ib.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    ib.rx_valid = 1'b0;
  endtask

  task automatic send_msg_a(input logic [31:0] m);
    for (int k = 0; k < 4; k++) send_a(m[byte_lsb(k) +: 8]);
  endtask

  task automatic send_msg_b(input logic [31:0] m);
    for (int k = 0; k < 4; k++) send_b(m[byte_lsb(k) +: 8]);
  endtask

  initial begin
    rst_n        = 1'b0;
    ia.rx_valid  = 1'b0;
    ia.rx_byte   = 8'h00;
    ia.msg_ready = 1'b0;
    ib.rx_valid  = 1'b0;
    ib.rx_byte   = 8'h00;
    ib.msg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_a_valid",   32'(ia.msg_valid),   32'd0);
    check("rst_a_data",    ia.msg_data,         32'd0);
    check("rst_a_cnt",     32'(ia.byte_cnt),    32'd0);
    check("rst_a_timeout", 32'(ia.timeout_err), 32'd0);
    check("rst_a_overrun", 32'(ia.overrun_err), 32'd0);
    check("rst_b_valid",   32'(ib.msg_valid),   32'd0);
    check("rst_b_data",    ib.msg_data,         32'd0);
    check("rst_b_cnt",     32'(ib.byte_cnt),    32'd0);
    rst_n = 1'b1;
    idle(1);

    // Basic assembly with the consumer always ready.
    ia.msg_ready = 1'b1;
    qa.push_back(32'h04030201);
    send_a(8'h01); send_a(8'h02); send_a(8'h03);
    check("t1_cnt3", 32'(ia.byte_cnt), 32'd3);
    send_a(8'h04);
    check("t1_valid_next_cycle", 32'(ia.msg_valid), 32'd1);
    check("t1_cnt_wrap",         32'(ia.byte_cnt),  32'd0);
    idle(1);
    check("t1_valid_one_cycle",  32'(ia.msg_valid), 32'd0);

    // Sync framing: leading junk ignored, sync byte not stored, sync-valued payload kept.
    ib.msg_ready = 1'b1;
    qb.push_back(32'h04030201);
    send_b(8'h11);
    check("t2_junk_ignored", 32'(ib.byte_cnt), 32'd0);
    send_b(8'hA5);
    check("t2_sync_not_counted", 32'(ib.byte_cnt), 32'd0);
    send_b(8'h01);
    check("t2_first_payload", 32'(ib.byte_cnt), 32'd1);
    send_b(8'h02); send_b(8'h03); send_b(8'h04);
    check("t2_valid", 32'(ib.msg_valid), 32'd1);
    send_b(8'h01);
    check("t2_rehunt", 32'(ib.byte_cnt), 32'd0);
    qb.push_back(32'h0D0C0B0A);
    send_b(8'hA5);
    send_msg_b(32'h0D0C0B0A);
    qb.push_back(32'hB3B2B1A5);
    send_b(8'hA5);
    send_msg_b(32'hB3B2B1A5);
    idle(2);

    // Overrun: holding buffer full, second message dropped, first one kept.
    ia.msg_ready = 1'b0;
    qa.push_back(32'h14131211);
    send_msg_a(32'h14131211);
    check("t3_valid_held", 32'(ia.msg_valid), 32'd1);
    send_msg_a(32'h24232221);
    check("t3_overrun_pulse", 32'(ia.overrun_err), 32'd1);
    check("t3_data_unchanged", ia.msg_data, 32'h14131211);
    check("t3_valid_still", 32'(ia.msg_valid), 32'd1);
    idle(1);
    check("t3_overrun_one_cycle", 32'(ia.overrun_err), 32'd0);
    check("t3_overrun_count", 32'(ov_a), 32'd1);
    ia.msg_ready = 1'b1;
    idle(1);
    check("t3_consumed", 32'(ia.msg_valid), 32'd0);

    // Timeout after 50 idle cycles discards the partial message.
    send_a(8'h31); send_a(8'h32);
    check("t4_cnt2", 32'(ia.byte_cnt), 32'd2);
    idle(50);
    check("t4_no_early_timeout", 32'(ia.timeout_err), 32'd0);
    check("t4_cnt_kept", 32'(ia.byte_cnt), 32'd2);
    idle(1);
    check("t4_timeout_pulse", 32'(ia.timeout_err), 32'd1);
    check("t4_cnt_cleared", 32'(ia.byte_cnt), 32'd0);
    idle(1);
    check("t4_timeout_one_cycle", 32'(ia.timeout_err), 32'd0);
    qa.push_back(32'h44434241);
    send_msg_a(32'h44434241);
    idle(1);

    // A byte on the expiry cycle is accepted and suppresses the timeout.
    qa.push_back(32'h54535251);
    send_a(8'h51); send_a(8'h52);
    idle(50);
    send_a(8'h53);
    check("t5_no_timeout", 32'(ia.timeout_err), 32'd0);
    check("t5_cnt3", 32'(ia.byte_cnt), 32'd3);
    send_a(8'h54);
    idle(1);
    check("t45_timeout_count", 32'(to_a), 32'd1);

    // Asynchronous reset with a held message and a partial one in progress.
    ia.msg_ready = 1'b0;
    send_msg_a(32'h74737271);
    send_a(8'h61); send_a(8'h62); send_a(8'h63);
    check("t6_pre_valid", 32'(ia.msg_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_valid",   32'(ia.msg_valid),   32'd0);
    check("t6_rst_data",    ia.msg_data,         32'd0);
    check("t6_rst_cnt",     32'(ia.byte_cnt),    32'd0);
    check("t6_rst_overrun", 32'(ia.overrun_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    qa.push_back(32'h84838281);
    send_msg_a(32'h84838281);
    check("t6_clean_msg", ia.msg_data, 32'h84838281);
    qa.push_back(32'h94939291);
    send_a(8'h91); send_a(8'h92); send_a(8'h93);
    ia.msg_ready = 1'b1;
    send_a(8'h94);
    check("t6_load_and_take_valid", 32'(ia.msg_valid), 32'd1);
    check("t6_load_and_take_data", ia.msg_data, 32'h94939291);
    idle(1);
    check("t6_drained", 32'(ia.msg_valid), 32'd0);

    idle(3);
    check("end_qa_empty", 32'(qa.size()), 32'd0);
    check("end_qb_empty", 32'(qb.size()), 32'd0);
    check("end_ov_a", 32'(ov_a), 32'd1);
    check("end_ov_b", 32'(ov_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
